// File: rtl/radians_arbiter_pkg.sv
// Shared types, fixed-point format and arithmetic helpers for radians_arbiter.
// The fixed-point format is Q16.16, with a 64-bit double-width product.
// PI and INV_180 are rounded to FLOAT_DCM_BITS fractional bits.
// Optional macro RADIANS_ARBITER_NORM_EN adds the S0 angle normalisation stage,
// which raises LATENCY from 2 to 3.
package radians_arbiter_pkg;

    localparam int unsigned INT_BITS          = 16;
    localparam int unsigned FLOAT_DCM_BITS    = 16;
    localparam int unsigned FLOAT_BITS        = INT_BITS + FLOAT_DCM_BITS;
    localparam int unsigned FLOAT_DOUBLE_BITS = 2 * FLOAT_BITS;
    localparam int unsigned WIDE_BITS         = FLOAT_DOUBLE_BITS + FLOAT_BITS;
    localparam int unsigned MAX_ID_BITS       = 4;

    // round(pi * 2^16) and round(2^16 / 180)
    localparam logic signed [FLOAT_DOUBLE_BITS-1:0] PI      = 64'sd205887;
    localparam logic signed [FLOAT_DOUBLE_BITS-1:0] INV_180 = 64'sd364;

`ifdef RADIANS_ARBITER_NORM_EN
    localparam int unsigned LATENCY = 3;
`else
    localparam int unsigned LATENCY = 2;
`endif

    typedef logic signed [FLOAT_BITS-1:0] rad_t;
    typedef logic signed [INT_BITS-1:0]   deg_t;

    typedef struct packed {
        logic                                valid;
        logic [MAX_ID_BITS-1:0]              id;
        logic signed [FLOAT_DOUBLE_BITS-1:0] data;
    } pipe_entry_t;

    // Fold an angle into (-180, 180] using a truncating remainder.
    function automatic deg_t norm_deg(input deg_t d);
        int r;
        r = int'(d) % 360;
        if (r > 180) begin
            r = r - 360;
        end else if (r <= -180) begin
            r = r + 360;
        end
        return deg_t'(r);
    endfunction

    // First product: {deg, FLOAT_DCM_BITS zeros} * PI at double width.
    function automatic logic signed [FLOAT_DOUBLE_BITS-1:0] scale_pi(
        input logic signed [FLOAT_DOUBLE_BITS-1:0] deg_ext
    );
        return (deg_ext <<< FLOAT_DCM_BITS) * PI;
    endfunction

    // Second product: widened to avoid overflow, then floored by the arithmetic shift.
    function automatic rad_t to_radians(input logic signed [FLOAT_DOUBLE_BITS-1:0] p1);
        logic signed [WIDE_BITS-1:0] prod;
        prod = WIDE_BITS'(p1) * WIDE_BITS'(INV_180);
        return rad_t'(prod >>> (2 * FLOAT_DCM_BITS));
    endfunction

endpackage

// File: rtl/radians_arbiter_rr.sv
// rr_arbiter: N-way round-robin grant with a pointer register.
// Ports: clk, rst (sync, active high), req[N] candidates, enable gates any grant,
//        accept loads the pointer with grant_idx, grant[N] one-hot,
//        grant_valid, grant_idx.
// The scan starts at pointer+1 (mod N). After reset the pointer is N-1, so index 0 wins first.
module rr_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned IDX_BITS = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        req,
    input  logic                enable,
    input  logic                accept,
    output logic [N-1:0]        grant,
    output logic                grant_valid,
    output logic [IDX_BITS-1:0] grant_idx
);

    logic [IDX_BITS-1:0] ptr;
    logic                found;
    int unsigned         cand;

    // First requester after the pointer, wrapping around.
    always_comb begin
        found     = 1'b0;
        grant_idx = ptr;
        cand      = 0;
        grant     = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = (32'(ptr) + k) % N;
            if (!found && req[IDX_BITS'(cand)]) begin
                found     = 1'b1;
                grant_idx = IDX_BITS'(cand);
            end
        end
        grant_valid = found && enable;
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // The pointer moves only on an accepted grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= IDX_BITS'(N - 1);
        end else if (accept) begin
            ptr <= grant_idx;
        end
    end

endmodule

// File: rtl/radians_arbiter.sv
// radians_arbiter: one shared degrees-to-radians pipeline for N_REQ requesters.
// Ports: clk, rst (sync, active high),
//        req_valid/req_deg/req_ready per requester, with req_deg packed as N_REQ x INT_BITS,
//        rsp_valid/rsp_id/rsp_rad/rsp_ready for the single result,
//        busy, which is high while any stage holds a valid entry.
// Optional macro RADIANS_ARBITER_NORM_EN adds stage S0. S0 folds the angle into (-180, 180].
// The whole pipeline advances together and freezes while the result is back-pressured.
module radians_arbiter
    import radians_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned ID_BITS = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*INT_BITS-1:0] req_deg,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      rsp_valid,
    output logic [ID_BITS-1:0]        rsp_id,
    output logic [FLOAT_BITS-1:0]     rsp_rad,
    input  logic                      rsp_ready,
    output logic                      busy
);

    logic               stall;
    logic               grant_valid;
    logic [ID_BITS-1:0] grant_idx;
    deg_t               deg_arr [N_REQ];
    deg_t               sel_deg;

    pipe_entry_t        in_entry, s1_src, s1_q, s1_d;
`ifdef RADIANS_ARBITER_NORM_EN
    pipe_entry_t        s0_q, s0_d;
`endif
    logic               rsp_valid_d;
    logic [ID_BITS-1:0] rsp_id_d;
    rad_t               rsp_rad_d;
    logic               busy_d;
    logic               unused_id_bits;

    assign stall = rsp_valid & ~rsp_ready;

    // Grants are issued only when the pipeline can move.
    rr_arbiter #(
        .N        (N_REQ),
        .IDX_BITS (ID_BITS)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req         (req_valid),
        .enable      (~stall),
        .accept      (grant_valid),
        .grant       (req_ready),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    for (genvar g = 0; g < N_REQ; g++) begin : g_deg
        assign deg_arr[g] = req_deg[g*INT_BITS +: INT_BITS];
    end

    assign sel_deg        = deg_arr[grant_idx];
    assign unused_id_bits = ^(s1_q.id >> ID_BITS);

    // Next-state for all stages: everything shifts together unless stalled.
    always_comb begin
        s1_d        = s1_q;
        rsp_valid_d = rsp_valid;
        rsp_id_d    = rsp_id;
        rsp_rad_d   = rad_t'(rsp_rad);

        in_entry       = '0;
        in_entry.valid = grant_valid;
        in_entry.id    = MAX_ID_BITS'(grant_idx);
`ifdef RADIANS_ARBITER_NORM_EN
        s0_d          = s0_q;
        in_entry.data = FLOAT_DOUBLE_BITS'(norm_deg(sel_deg));
        s1_src        = s0_q;
`else
        in_entry.data = FLOAT_DOUBLE_BITS'(sel_deg);
        s1_src        = in_entry;
`endif

        if (!stall) begin
`ifdef RADIANS_ARBITER_NORM_EN
            s0_d = in_entry;
`endif
            s1_d.valid  = s1_src.valid;
            s1_d.id     = s1_src.id;
            s1_d.data   = scale_pi(s1_src.data);
            rsp_valid_d = s1_q.valid;
            if (s1_q.valid) begin
                rsp_id_d  = ID_BITS'(s1_q.id);
                rsp_rad_d = to_radians(s1_q.data);
            end
        end

`ifdef RADIANS_ARBITER_NORM_EN
        busy_d = s0_d.valid | s1_d.valid | rsp_valid_d;
`else
        busy_d = s1_d.valid | rsp_valid_d;
`endif
    end

    // Stage registers. Reset drops every in-flight entry.
    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef RADIANS_ARBITER_NORM_EN
            s0_q      <= '0;
`endif
            s1_q      <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_rad   <= '0;
            busy      <= 1'b0;
        end else begin
`ifdef RADIANS_ARBITER_NORM_EN
            s0_q      <= s0_d;
`endif
            s1_q      <= s1_d;
            rsp_valid <= rsp_valid_d;
            rsp_id    <= rsp_id_d;
            rsp_rad   <= rsp_rad_d;
            busy      <= busy_d;
        end
    end

endmodule
